mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/tinker_pkg.sv | 16 +
 rtl/arb_priority_sel.sv | 32 +++
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tinker_pkg.sv
// Shared types and sizing for the memory port arbiter: state encoding,
// bus widths and the default shared-memory capacity.
package tinker_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 64;
  localparam int INSTR_W          = 32;
  localparam int MEM_SIZE_DEFAULT = 524288;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner selection between fetch and data requests.
// With ARB_STARVE_GUARD_EN defined, a starved fetch port wins once its loss count hits STARVE_LIMIT.
module arb_priority_sel
`ifdef ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
)
`endif
(
  input  logic             if_req,
  input  logic             dm_req,
`ifdef ARB_STARVE_GUARD_EN
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             sel_if,
  output logic             sel_dm
);

  logic force_if;

  always_comb begin
`ifdef ARB_STARVE_GUARD_EN
    force_if = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    force_if = 1'b0;
`endif
    sel_dm = dm_req & ~(if_req & force_if);
    sel_if = if_req & ~sel_dm;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory, one transaction in flight.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import tinker_pkg::*;
#(
  parameter int MEM_SIZE     = MEM_SIZE_DEFAULT,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [INSTR_W-1:0] if_rdata,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic               dm_gnt,
  output logic               dm_rvalid,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               dm_err,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] DM_LAST   = ADDR_W'(MEM_SIZE - 8);
  localparam logic [ADDR_W-1:0] IF_LAST   = ADDR_W'(MEM_SIZE - 4);
  localparam logic [1:0]        WAIT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;
  localparam arb_state_t        READ_NEXT = (LATENCY > 1) ? WAIT : RESP;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              own_dm_q, own_dm_d;
  logic              fault_q, fault_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic              sel_if, sel_dm;
  logic              dm_oor, if_oor;

  assign dm_oor = (dm_addr > DM_LAST);
  assign if_oor = (if_addr > IF_LAST);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  arb_priority_sel #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_sel (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .starve_cnt(starve_q),
    .sel_if    (sel_if),
    .sel_dm    (sel_dm)
  );

  // Count only real losses: both requesting in IDLE and data taking the slot.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (sel_if) begin
        starve_d = '0;
      end else if (sel_dm && if_req && (starve_q != CNT_W'(STARVE_LIMIT))) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  arb_priority_sel u_sel (
    .if_req(if_req),
    .dm_req(dm_req),
    .sel_if(sel_if),
    .sel_dm(sel_dm)
  );
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    own_dm_d  = own_dm_q;
    fault_d   = fault_q;
    wcnt_d    = wcnt_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    dm_err    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_dm) begin
          dm_gnt    = 1'b1;
          mem_en    = ~dm_oor;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          if (dm_we) begin
            // Writes complete in the grant cycle; only a fault produces a response.
            mem_we    = ~dm_oor;
            dm_rvalid = dm_oor;
            dm_err    = dm_oor;
          end else begin
            addr_d   = dm_addr;
            own_dm_d = 1'b1;
            fault_d  = dm_oor;
            wcnt_d   = WAIT_INIT;
            state_d  = READ_NEXT;
          end
        end else if (sel_if) begin
          if_gnt   = 1'b1;
          mem_en   = ~if_oor;
          mem_addr = if_addr;
          addr_d   = if_addr;
          own_dm_d = 1'b0;
          fault_d  = if_oor;
          wcnt_d   = WAIT_INIT;
          state_d  = READ_NEXT;
        end
      end
      WAIT: begin
        busy     = 1'b1;
        mem_en   = ~fault_q;
        mem_addr = addr_q;
        if (wcnt_q == 2'd0) begin
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      RESP: begin
        busy     = 1'b1;
        mem_en   = ~fault_q;
        mem_addr = addr_q;
        state_d  = IDLE;
        if (own_dm_q) begin
          dm_rvalid = 1'b1;
          dm_err    = fault_q;
          dm_rdata  = fault_q ? '0 : mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = fault_q ? '0 : mem_rdata[INSTR_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output at once, even while IDLE sees a request.
    if (reset) begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata  = '0;
      dm_err    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      own_dm_q <= 1'b0;
      fault_q  <= 1'b0;
      wcnt_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      own_dm_q <= own_dm_d;
      fault_q  <= fault_d;
      wcnt_q   <= wcnt_d;
    end
  end

endmodule
